instruction_store: RTL and testbench
====================================

# instruction_store

Parametrised, bus-writable instruction memory with a built-in sequential fetch engine. It sits on the shared 16-bit memory-mapped bus as the instruction peripheral, decoded by address bits [15:12]. Software loads programs through bus writes, and the bus can read words back. The execution engine streams instructions through a ready/valid fetch port that auto-increments the program counter and halts on a STOP opcode (8'hFF).

## Interface
Parameters:
- INSTR_W, 32, instruction word width; opcode is bits [INSTR_W-1:INSTR_W-8]
- DEPTH, 16, number of instruction words; must be ≤ 4096
- BUS_W, 256, data bus width; must be ≥ INSTR_W
- SEL, 4'h1, value of address[15:12] that selects this block
- AW, $clog2(DEPTH), program counter width

Ports:
- Clk  in  1  clock, all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- address  in  16  bus address; [15:12] select, [11:0] word index
- nRead  in  1  active-low bus read request
- nWrite  in  1  active-low bus write request
- DataIn  in  BUS_W  bus write data; low INSTR_W bits are stored
- DataOut  out  BUS_W  bus read data, zero-extended word
- DataValid  out  1  one-cycle pulse marking fresh DataOut
- fetch_start  in  1  pulse that loads the PC from fetch_addr and starts fetching
- fetch_addr  in  AW  start address for the fetch engine
- instr_ready  in  1  consumer accepts instr_out this cycle
- instr_valid  out  1  instr_out holds a valid instruction
- instr_out  out  INSTR_W  fetched instruction
- instr_pc  out  AW  address of instr_out
- halted  out  1  fetch engine stopped on STOP or an out-of-range address

## Operation
- Reset (asynchronous, nReset=0):
  - Every memory word is set to 32'hFF_FF_FF_FF (STOP), except where INSTR_STORE_DEFAULT_PROG_EN applies.
  - DataOut=0, DataValid=0, instr_valid=0, instr_out=0, instr_pc=0, halted=0.
  - The fetch FSM enters IDLE.
- Bus hit: address[15:12]==SEL and address[11:0] < DEPTH.
- Bus write: bus hit and nWrite=0. mem[address[11:0]] <= DataIn[INSTR_W-1:0] at the clock edge.
- Bus read: bus hit, nRead=0 and nWrite=1. On the next cycle DataOut = zero-extended mem[index] and DataValid=1 for one cycle.
- nRead=0 and nWrite=0 together: the write is performed and no read occurs.
- Select matches but index ≥ DEPTH:
  - Write: ignored.
  - Read: DataOut=0 with a DataValid pulse.
- Outside a read, DataOut holds its last value.
- Fetch FSM states:
  - IDLE → FETCH on fetch_start.
  - FETCH: instr_valid=1. On a handshake (instr_valid & instr_ready):
    - Opcode ≠ 8'hFF: the PC increments, wrapping DEPTH-1 → 0, and the next word is presented.
    - Opcode == 8'hFF: the FSM moves to HALT.
  - FETCH with instr_ready=0: the FSM stalls and instr_out/instr_pc are held stable.
  - HALT: halted=1, instr_valid=0. Moves to FETCH on fetch_start.
- fetch_start is honoured in any state and overrides a simultaneous handshake. It clears halted.
- fetch_start with fetch_addr ≥ DEPTH (non-power-of-2 DEPTH): the FSM goes to HALT with halted=1 and never asserts instr_valid.
- Bus writes do not update a word already registered in instr_out. Words fetched after the write see the new data.

## Timing
- Bus read latency: 1 cycle (request at cycle N, DataOut/DataValid at N+1). Back-to-back reads give one result per cycle.
- Write then read of the same index on the next cycle returns the new data.
- Fetch start: fetch_start at cycle N gives instr_valid=1, instr_out=mem[fetch_addr], instr_pc=fetch_addr at N+1.
- Handshake on a non-STOP word at cycle k: the next word is valid at k+1. Throughput is 1 instruction/cycle.
- Handshake on STOP at cycle k: instr_valid=0 and halted=1 at k+1.
- Same-cycle bus write and fetch to the same index: the fetch returns the old word (read-before-write).
- Reset mid-stream: outputs go to their reset values immediately and the FSM enters IDLE; a pending fetch is discarded.

## Configuration
- INSTR_STORE_DEFAULT_PROG_EN defined:
  - Reset loads words 0-9 with 01020001, FF000000, 02030300, 030401FF, 04050380, 00060403, 120A0001, 110A0181, 130B0A81, FFFFFFFF (hex).
  - Words 10 and above reset to STOP.
  - Requires DEPTH ≥ 10; the elaboration error fires otherwise.
- Undefined: all words reset to 32'hFFFFFFFF.

## Test plan
- Bus write/read-back: write 32'h12345678 to address 16'h1003; read 16'h1003 → next cycle DataOut=256'h12345678, DataValid=1 for exactly one cycle.
- Decode/range:
  - Read 16'h2003 → no DataValid.
  - Read 16'h1010 with DEPTH=16 → DataOut=0 with a DataValid pulse.
  - Write 16'h1010 → memory unchanged.
- Streaming fetch:
  - Setup: load 10,11,12,FF000000 at 0-3; fetch_start with fetch_addr=0; instr_ready=1.
  - Response: instr_out 10,11,12,FF000000 on four consecutive cycles with instr_pc 0-3; then halted=1, instr_valid=0.
- Stall and restart:
  - Hold instr_ready=0 for 3 cycles mid-stream → instr_out/instr_pc stable.
  - fetch_start to addr 2 during the stall → next cycle instr_pc=2.
- Wrap and reset:
  - No STOP at word 15; fetch from 14 → instr_pc 14, 15, 0.
  - Assert nReset mid-stream → instr_valid=0, halted=0, and all words read back FFFFFFFF (macro undefined).

Source files
------------

// File: rtl/instruction_store.sv
// Bus-writable instruction memory with a ready/valid sequential fetch engine; bus reads 1-cycle latency, fetch 1 instr/cycle.
// Optional build macro INSTR_STORE_DEFAULT_PROG_EN preloads a demo program at reset; fetch stalls while instr_ready is low.
module instruction_store #(
  parameter int          INSTR_W = 32,
  parameter int          DEPTH   = 16,
  parameter int          BUS_W   = 256,
  parameter logic [3:0]  SEL     = 4'h1,
  parameter int          AW      = $clog2(DEPTH)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [15:0]        address,
  input  logic               nRead,
  input  logic               nWrite,
  input  logic [BUS_W-1:0]   DataIn,
  output logic [BUS_W-1:0]   DataOut,
  output logic               DataValid,
  input  logic               fetch_start,
  input  logic [AW-1:0]      fetch_addr,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [AW-1:0]      instr_pc,
  output logic               halted
);

  localparam logic [INSTR_W-1:0] STOP_WORD = '1;
  localparam logic [7:0]         STOP_OP   = 8'hFF;
  localparam logic [AW-1:0]      PC_LAST   = AW'(DEPTH - 1);
  localparam logic [12:0]        DEPTH_BUS = 13'(DEPTH);
  localparam logic [AW:0]        DEPTH_PC  = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  if (DEPTH < 2 || DEPTH > 4096) begin : g_bad_depth
    $error("instruction_store: DEPTH must be in 2..4096");
  end
  if (BUS_W < INSTR_W) begin : g_bad_bus
    $error("instruction_store: BUS_W must be >= INSTR_W");
  end
  if (INSTR_W < 8) begin : g_bad_instr
    $error("instruction_store: INSTR_W must hold an 8-bit opcode");
  end
`ifdef INSTR_STORE_DEFAULT_PROG_EN
  if (DEPTH < 10) begin : g_bad_prog
    $error("instruction_store: default program needs DEPTH >= 10");
  end

  function automatic logic [INSTR_W-1:0] default_word(input int idx);
    case (idx)
      0:       return INSTR_W'(32'h01020001);
      1:       return INSTR_W'(32'hFF000000);
      2:       return INSTR_W'(32'h02030300);
      3:       return INSTR_W'(32'h030401FF);
      4:       return INSTR_W'(32'h04050380);
      5:       return INSTR_W'(32'h00060403);
      6:       return INSTR_W'(32'h120A0001);
      7:       return INSTR_W'(32'h110A0181);
      8:       return INSTR_W'(32'h130B0A81);
      default: return STOP_WORD;
    endcase
  endfunction
`endif

  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic [BUS_W-1:0]   data_out_q;
  logic               data_vld_q;
  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic          sel_hit, idx_ok, bus_wr, bus_rd;
  logic [AW-1:0] bus_idx;
  logic          unused_bus;

  assign sel_hit = (address[15:12] == SEL);
  assign idx_ok  = ({1'b0, address[11:0]} < DEPTH_BUS);
  assign bus_idx = address[AW-1:0];
  // A simultaneous read+write request is treated purely as a write.
  assign bus_wr  = sel_hit & idx_ok & ~nWrite;
  assign bus_rd  = sel_hit & ~nRead & nWrite;
  assign unused_bus = ^DataIn;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef INSTR_STORE_DEFAULT_PROG_EN
        mem_q[i] <= default_word(i);
`else
        mem_q[i] <= STOP_WORD;
`endif
      end
    end else if (bus_wr) begin
      mem_q[bus_idx] <= DataIn[INSTR_W-1:0];
    end
  end

  // Out-of-range reads still pulse DataValid so the bus master never waits.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      data_out_q <= '0;
      data_vld_q <= 1'b0;
    end else begin
      data_vld_q <= bus_rd;
      if (bus_rd) begin
        data_out_q <= idx_ok ? BUS_W'(mem_q[bus_idx]) : '0;
      end
    end
  end

  assign DataOut   = data_out_q;
  assign DataValid = data_vld_q;

  logic          start_ok, handshake, is_stop;
  logic [AW-1:0] pc_inc;

  assign start_ok  = ({1'b0, fetch_addr} < DEPTH_PC);
  assign handshake = (state_q == S_FETCH) & instr_ready;
  assign is_stop   = (instr_q[INSTR_W-1 -: 8] == STOP_OP);
  assign pc_inc    = (pc_q == PC_LAST) ? '0 : pc_q + AW'(1);

  // Memory is sampled before this edge's bus write lands, giving read-before-write.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (fetch_start) begin
      if (start_ok) begin
        state_d = S_FETCH;
        pc_d    = fetch_addr;
        instr_d = mem_q[fetch_addr];
      end else begin
        state_d = S_HALT;
      end
    end else if (handshake) begin
      if (is_stop) begin
        state_d = S_HALT;
      end else begin
        pc_d    = pc_inc;
        instr_d = mem_q[pc_inc];
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign instr_valid = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign instr_out   = instr_q;
  assign instr_pc    = pc_q;

endmodule

// File: tb/tb_instruction_store.sv
// Directed bench for instruction_store: bus access, decode/range, streaming fetch, stall/restart, wrap, reset.
module tb_instruction_store;

  logic         Clk;
  logic         nReset;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;
  logic [255:0] DataIn;
  logic [255:0] DataOut;
  logic         DataValid;
  logic         fetch_start;
  logic [3:0]   fetch_addr;
  logic         instr_ready;
  logic         instr_valid;
  logic [31:0]  instr_out;
  logic [3:0]   instr_pc;
  logic         halted;

  int errors = 0;
  int checks = 0;

  instruction_store dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .address     (address),
    .nRead       (nRead),
    .nWrite      (nWrite),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .DataValid   (DataValid),
    .fetch_start (fetch_start),
    .fetch_addr  (fetch_addr),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    address = a;
    DataIn  = {224'd0, d};
    nWrite  = 1'b0;
    tick();
    nWrite  = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a);
    address = a;
    nRead   = 1'b0;
    tick();
    nRead   = 1'b1;
  endtask

  task automatic start_fetch(input logic [3:0] a);
    fetch_addr  = a;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [3:0] pc, input logic [31:0] ins);
    check({tag, "_vld"}, 256'(instr_valid), 256'(1'b1));
    check({tag, "_pc"},  256'(instr_pc), 256'(pc));
    check({tag, "_ins"}, 256'(instr_out), 256'(ins));
  endtask

  initial begin
    nReset = 1'b0; address = '0; nRead = 1'b1; nWrite = 1'b1; DataIn = '0;
    fetch_start = 1'b0; fetch_addr = '0; instr_ready = 1'b0;
    repeat (2) tick();
    check("rst_dout",   DataOut, 256'd0);
    check("rst_dvld",   256'(DataValid), 256'd0);
    check("rst_ivld",   256'(instr_valid), 256'd0);
    check("rst_iout",   256'(instr_out), 256'd0);
    check("rst_ipc",    256'(instr_pc), 256'd0);
    check("rst_halted", 256'(halted), 256'd0);
    nReset = 1'b1;
    tick();

    // write/read-back, one-cycle DataValid pulse, DataOut holds afterwards
    bus_write(16'h1003, 32'h12345678);
    bus_read(16'h1003);
    check("rd_dout", DataOut, 256'h12345678);
    check("rd_dvld", 256'(DataValid), 256'd1);
    tick();
    check("rd_dvld_drop", 256'(DataValid), 256'd0);
    check("rd_dout_hold", DataOut, 256'h12345678);

    // decode and range
    bus_read(16'h2003);
    check("nosel_dvld", 256'(DataValid), 256'd0);
    bus_read(16'h1010);
    check("oor_dvld", 256'(DataValid), 256'd1);
    check("oor_dout", DataOut, 256'd0);
    bus_write(16'h1010, 32'h0000DEAD);
    bus_read(16'h1000);
    check("oor_wr_alias", DataOut, 256'hFFFFFFFF);

    // read+write together: write wins, no read pulse
    address = 16'h1005; DataIn = 256'hAA; nRead = 1'b0; nWrite = 1'b0;
    tick();
    nRead = 1'b1; nWrite = 1'b1;
    check("rw_dvld", 256'(DataValid), 256'd0);
    bus_read(16'h1005);
    check("rw_data", DataOut, 256'hAA);

    // streaming fetch to STOP
    bus_write(16'h1000, 32'h10);
    bus_write(16'h1001, 32'h11);
    bus_write(16'h1002, 32'h12);
    bus_write(16'h1003, 32'hFF000000);
    instr_ready = 1'b1;
    start_fetch(4'd0);
    check_fetch("s0", 4'd0, 32'h10);
    tick();
    check_fetch("s1", 4'd1, 32'h11);
    tick();
    check_fetch("s2", 4'd2, 32'h12);
    tick();
    check_fetch("s3", 4'd3, 32'hFF000000);
    tick();
    check("stop_ivld",   256'(instr_valid), 256'd0);
    check("stop_halted", 256'(halted), 256'd1);

    // restart from HALT, stall, restart during stall, start overriding handshake
    instr_ready = 1'b0;
    start_fetch(4'd0);
    check("restart_halted", 256'(halted), 256'd0);
    check_fetch("r0", 4'd0, 32'h10);
    instr_ready = 1'b1;
    tick();
    check_fetch("r1", 4'd1, 32'h11);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("stall", 4'd1, 32'h11);
    end
    start_fetch(4'd2);
    check_fetch("stall_restart", 4'd2, 32'h12);
    instr_ready = 1'b1;
    start_fetch(4'd0);
    check_fetch("start_override", 4'd0, 32'h10);
    instr_ready = 1'b0;

    // same-cycle write and fetch of one index: fetch sees the old word
    address = 16'h1001; DataIn = 256'h55; nWrite = 1'b0;
    fetch_addr = 4'd1; fetch_start = 1'b1;
    tick();
    nWrite = 1'b1; fetch_start = 1'b0;
    check_fetch("rbw_old", 4'd1, 32'h11);
    start_fetch(4'd1);
    check_fetch("rbw_new", 4'd1, 32'h55);
    bus_write(16'h1001, 32'h66);
    check_fetch("held_word", 4'd1, 32'h55);

    // wrap from DEPTH-1 to 0
    bus_write(16'h100E, 32'h0E);
    bus_write(16'h100F, 32'h0F);
    instr_ready = 1'b1;
    start_fetch(4'd14);
    check_fetch("w14", 4'd14, 32'h0E);
    tick();
    check_fetch("w15", 4'd15, 32'h0F);
    tick();
    check_fetch("w0", 4'd0, 32'h10);

    // asynchronous reset mid-stream
    nReset = 1'b0;
    #1;
    check("mrst_ivld",   256'(instr_valid), 256'd0);
    check("mrst_halted", 256'(halted), 256'd0);
    check("mrst_ipc",    256'(instr_pc), 256'd0);
    check("mrst_iout",   256'(instr_out), 256'd0);
    check("mrst_dout",   DataOut, 256'd0);
    instr_ready = 1'b0;
    tick();
    nReset = 1'b1;
    tick();
    nRead = 1'b0;
    for (int i = 0; i < 16; i++) begin
      address = 16'h1000 | 16'(i);
      tick();
      check($sformatf("mrst_mem%0d", i), DataOut, 256'hFFFFFFFF);
      check($sformatf("mrst_mvld%0d", i), 256'(DataValid), 256'd1);
    end
    nRead = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
